// File: rtl/bayer_pkg.sv
// ============================================================================
// Module : bayer_pkg
// Brief  : Shared state encoding, colour-select codes and widths for the
//          RGB-to-Bayer re-mosaic path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bayer_pkg;

  localparam int PIX_W = 12;
  localparam int CNT_W = 12;
  localparam int BLK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] CS_R  = 2'b00;
  localparam logic [1:0] CS_G0 = 2'b01;
  localparam logic [1:0] CS_G1 = 2'b10;
  localparam logic [1:0] CS_B  = 2'b11;

  function automatic logic [PIX_W-1:0] color_sel(
    input logic [1:0]       cs,
    input logic [PIX_W-1:0] r,
    input logic [PIX_W-1:0] g,
    input logic [PIX_W-1:0] b
  );
    case (cs)
      CS_R:         return r;
      CS_G0, CS_G1: return g;
      default:      return b;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bayer_xy_counter.sv
// ============================================================================
// Module : bayer_xy_counter
// Brief  : Column/row position counters with line-end and frame-end flags,
//          synchronous clear and SOF restart.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bayer_xy_counter
  import bayer_pkg::*;
#(
  parameter int VIDEO_W = 800,
  parameter int VIDEO_H = 600
) (
  input  logic             BAYER_CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             restart,
  input  logic             step,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] c_x_last = CNT_W'(VIDEO_W - 1);
  localparam logic [CNT_W-1:0] c_y_last = CNT_W'(VIDEO_H - 1);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  assign line_end  = (r_x == c_x_last);
  assign frame_end = line_end && (r_y == c_y_last);
  assign x         = r_x;
  assign y         = r_y;

  // A restart consumes pixel (0,0), so the next expected column is 1.
  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (restart) begin
      r_x <= CNT_W'(1);
      r_y <= '0;
    end else if (step) begin
      if (line_end) begin
        r_x <= '0;
        r_y <= frame_end ? '0 : r_y + CNT_W'(1);
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb2bayer_mosaic.sv
// ============================================================================
// Module : rgb2bayer_mosaic
// Brief  : Re-mosaics an RGB pixel stream into a 12-bit Bayer stream with
//          horizontal/vertical blanking. Optional BAYER_FRAME_COUNT_EN adds a
//          completed-frame counter output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb2bayer_mosaic
  import bayer_pkg::*;
#(
  parameter int         VIDEO_W     = 800,
  parameter int         VIDEO_H     = 600,
  parameter int         H_BLANK     = 16,
  parameter int         V_BLANK     = 64,
  parameter logic [1:0] BAYER_PHASE = 2'd0
) (
  input  logic             BAYER_CLK,
  input  logic             reset,
  input  logic [PIX_W-1:0] RGB_R,
  input  logic [PIX_W-1:0] RGB_G,
  input  logic [PIX_W-1:0] RGB_B,
  input  logic             RGB_VALID,
  input  logic             RGB_SOF,
  output logic             RGB_READY,
  output logic [CNT_W-1:0] BAYER_X,
  output logic [CNT_W-1:0] BAYER_Y,
  output logic [PIX_W-1:0] BAYER_DATA,
  output logic             BAYER_VALID,
  output logic [CNT_W-1:0] BAYER_WIDTH,
  output logic [CNT_W-1:0] BAYER_HEIGHT
`ifdef BAYER_FRAME_COUNT_EN
  ,
  output logic [19:0]      BAYER_FRAME_COUNT
`endif
);

  state_t           r_state;
  state_t           w_next_state;
  logic [BLK_W-1:0] r_blk_cnt;
  logic [BLK_W-1:0] w_blk_next;
  logic             r_ready;

  logic             w_accept;
  logic             w_sof;
  logic             w_emit;
  logic             w_step;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_line_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_pix_x;
  logic [CNT_W-1:0] w_pix_y;
  logic [1:0]       w_cs;

  logic [CNT_W-1:0] r_out_x;
  logic [CNT_W-1:0] r_out_y;
  logic [PIX_W-1:0] r_out_data;
  logic             r_out_valid;

  assign w_accept = RGB_VALID && r_ready;
  assign w_sof    = w_accept && RGB_SOF;
  assign w_emit   = w_sof || (w_accept && (r_state == ST_ACTIVE));
  assign w_step   = w_emit && !RGB_SOF;

  bayer_xy_counter #(
    .VIDEO_W (VIDEO_W),
    .VIDEO_H (VIDEO_H)
  ) u_xy (
    .BAYER_CLK (BAYER_CLK),
    .reset     (reset),
    .clr       (r_state == ST_VBLANK),
    .restart   (w_sof),
    .step      (w_step),
    .x         (w_x),
    .y         (w_y),
    .line_end  (w_line_end),
    .frame_end (w_frame_end)
  );

  // A SOF pixel is always (0,0) regardless of where the counters were.
  assign w_pix_x = RGB_SOF ? '0 : w_x;
  assign w_pix_y = RGB_SOF ? '0 : w_y;
  assign w_cs    = {w_pix_y[0], w_pix_x[0]} ^ BAYER_PHASE;

  always_comb begin
    w_next_state = r_state;
    w_blk_next   = r_blk_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sof) w_next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_step && w_line_end) begin
          if (w_frame_end) begin
            w_next_state = ST_VBLANK;
            w_blk_next   = BLK_W'(V_BLANK - 1);
          end else begin
            w_next_state = ST_HBLANK;
            w_blk_next   = BLK_W'(H_BLANK - 1);
          end
        end
      end
      ST_HBLANK: begin
        if (r_blk_cnt == '0) w_next_state = ST_ACTIVE;
        else                 w_blk_next   = r_blk_cnt - BLK_W'(1);
      end
      ST_VBLANK: begin
        if (r_blk_cnt == '0) w_next_state = ST_IDLE;
        else                 w_blk_next   = r_blk_cnt - BLK_W'(1);
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low while in reset.
  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_blk_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_blk_cnt <= w_blk_next;
      r_ready   <= (w_next_state == ST_IDLE) || (w_next_state == ST_ACTIVE);
    end
  end

  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset) begin
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_emit) begin
      r_out_x     <= w_pix_x;
      r_out_y     <= w_pix_y;
      r_out_data  <= color_sel(w_cs, RGB_R, RGB_G, RGB_B);
      r_out_valid <= 1'b1;
    end else begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end
  end

`ifdef BAYER_FRAME_COUNT_EN
  logic [19:0] r_frame_cnt;

  // Only a normally completed frame counts; a SOF on the last pixel is a restart.
  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset)                     r_frame_cnt <= '0;
    else if (w_step && w_frame_end) r_frame_cnt <= r_frame_cnt + 20'd1;
  end

  assign BAYER_FRAME_COUNT = r_frame_cnt;
`endif

  assign RGB_READY    = r_ready;
  assign BAYER_X      = r_out_x;
  assign BAYER_Y      = r_out_y;
  assign BAYER_DATA   = r_out_data;
  assign BAYER_VALID  = r_out_valid;
  assign BAYER_WIDTH  = CNT_W'(VIDEO_W);
  assign BAYER_HEIGHT = CNT_W'(VIDEO_H);

endmodule

`default_nettype wire

// File: tb/tb_rgb2bayer_mosaic.sv
// ============================================================================
// Module : tb_rgb2bayer_mosaic
// Brief  : Self-checking bench for rgb2bayer_mosaic (4x2 frame, short blanks).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb2bayer_mosaic;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] in_r = '0, in_g = '0, in_b = '0;
  logic        in_valid = 1'b0, in_sof = 1'b0;

  logic        rdy, b_valid, p3_rdy, p3_valid;
  logic [11:0] b_x, b_y, b_data, b_w, b_h;
  logic [11:0] p3_x, p3_y, p3_data, p3_w, p3_h;
`ifdef BAYER_FRAME_COUNT_EN
  logic [19:0] fc, fc_p3;
  logic [19:0] fc_saved;
`endif

  always #5 clk = ~clk;

  rgb2bayer_mosaic #(.VIDEO_W(W), .VIDEO_H(H), .H_BLANK(2), .V_BLANK(3), .BAYER_PHASE(2'd0)) dut (
    .BAYER_CLK(clk), .reset(reset), .RGB_R(in_r), .RGB_G(in_g), .RGB_B(in_b),
    .RGB_VALID(in_valid), .RGB_SOF(in_sof), .RGB_READY(rdy),
    .BAYER_X(b_x), .BAYER_Y(b_y), .BAYER_DATA(b_data), .BAYER_VALID(b_valid),
    .BAYER_WIDTH(b_w), .BAYER_HEIGHT(b_h)
`ifdef BAYER_FRAME_COUNT_EN
    , .BAYER_FRAME_COUNT(fc)
`endif
  );

  rgb2bayer_mosaic #(.VIDEO_W(W), .VIDEO_H(H), .H_BLANK(2), .V_BLANK(3), .BAYER_PHASE(2'd3)) dut_p3 (
    .BAYER_CLK(clk), .reset(reset), .RGB_R(in_r), .RGB_G(in_g), .RGB_B(in_b),
    .RGB_VALID(in_valid), .RGB_SOF(in_sof), .RGB_READY(p3_rdy),
    .BAYER_X(p3_x), .BAYER_Y(p3_y), .BAYER_DATA(p3_data), .BAYER_VALID(p3_valid),
    .BAYER_WIDTH(p3_w), .BAYER_HEIGHT(p3_h)
`ifdef BAYER_FRAME_COUNT_EN
    , .BAYER_FRAME_COUNT(fc_p3)
`endif
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] d;
  } exp_t;

  typedef struct {
    logic [11:0] r, g, b;
    logic        sof;
    logic [11:0] ex, ey, ed;
  } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_x = 0;
  int   m_y = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] sel(input int x, input int y,
                                      input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    logic [1:0] c;
    c = {y[0], x[0]};
    case (c)
      2'b00:   return r;
      2'b11:   return b;
      default: return g;
    endcase
  endfunction

  // Waits (bounded) for ready, presents one pixel for one cycle.
  task automatic drive(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                       input logic sof, input logic push,
                       input logic [11:0] ex, input logic [11:0] ey, input logic [11:0] ed);
    int n = 0;
    while (!rdy && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required 1", n);
      return;
    end
    in_r = r; in_g = g; in_b = b; in_sof = sof; in_valid = 1'b1;
    if (push) q.push_back('{x: ex, y: ey, d: ed});
    @(negedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic px_rgb(input logic sof, input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    if (sof) begin m_x = 0; m_y = 0; end
    drive(r, g, b, sof, 1'b1, 12'(m_x), 12'(m_y), sel(m_x, m_y, r, g, b));
    m_x++;
    if (m_x == W) begin
      m_x = 0;
      m_y++;
      if (m_y == H) m_y = 0;
    end
  endtask

  task automatic px(input logic sof);
    px_rgb(sof, 12'($urandom), 12'($urandom), 12'($urandom));
  endtask

  task automatic step_chk_ready(input logic req, input string name);
    @(negedge clk); #1;
    chk(name, {31'd0, rdy}, {31'd0, req});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (b_valid) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got x=%0d y=%0d data=0x%0h, required no output", b_x, b_y, b_data);
        end else begin
          e = q.pop_front();
          if (b_x !== e.x || b_y !== e.y || b_data !== e.d) begin
            n_fail++;
            $display("FAIL pixel: got (%0d,%0d,0x%0h) required (%0d,%0d,0x%0h)",
                     b_x, b_y, b_data, e.x, e.y, e.d);
          end
        end
      end else if (b_data !== 12'd0) begin
        n_fail++;
        $display("FAIL idle_data: got 0x%0h required 0x0", b_data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].r   = 12'h100 + 12'(i);
      tbl[i].g   = 12'h200 + 12'(i);
      tbl[i].b   = 12'h300 + 12'(i);
      tbl[i].sof = (i == 0);
    end
    tbl[0].ex = 0; tbl[0].ey = 0; tbl[0].ed = 12'h100;
    tbl[1].ex = 1; tbl[1].ey = 0; tbl[1].ed = 12'h201;
    tbl[2].ex = 2; tbl[2].ey = 0; tbl[2].ed = 12'h102;
    tbl[3].ex = 3; tbl[3].ey = 0; tbl[3].ed = 12'h203;
    tbl[4].ex = 0; tbl[4].ey = 1; tbl[4].ed = 12'h204;
    tbl[5].ex = 1; tbl[5].ey = 1; tbl[5].ed = 12'h305;
    tbl[6].ex = 2; tbl[6].ey = 1; tbl[6].ed = 12'h206;
    tbl[7].ex = 3; tbl[7].ey = 1; tbl[7].ed = 12'h307;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, b_valid}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_x", {20'd0, b_x}, 32'd0);
    chk("rst_y", {20'd0, b_y}, 32'd0);
    chk("rst_data", {20'd0, b_data}, 32'd0);
    chk("width", {20'd0, b_w}, W);
    chk("height", {20'd0, b_h}, H);
    reset = 1'b0;
    step_chk_ready(1'b1, "ready_after_rst");

    // 1: continuous frame from the table, with blanking ready checks
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].sof, 1'b1, tbl[i].ex, tbl[i].ey, tbl[i].ed);
      if (i == 3) begin
        chk("hblank_ready0", {31'd0, rdy}, 32'd0);
        step_chk_ready(1'b0, "hblank_ready1");
        step_chk_ready(1'b1, "hblank_end");
      end
      if (i == 7) begin
        chk("vblank_ready0", {31'd0, rdy}, 32'd0);
        step_chk_ready(1'b0, "vblank_ready1");
        step_chk_ready(1'b0, "vblank_ready2");
        step_chk_ready(1'b1, "vblank_end");
      end
    end
`ifdef BAYER_FRAME_COUNT_EN
    chk("fc_frame1", {12'd0, fc}, 32'd1);
`endif

    // 2: pixels before SOF are dropped
    for (int i = 0; i < 3; i++) drive(12'h111, 12'h222, 12'h333, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("drop_novalid", {31'd0, b_valid}, 32'd0);
    #1;
    px(1'b1);

    // 3: stall of 5 cycles at x=2
    px(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_novalid", {31'd0, b_valid}, 32'd0);
    end
    #1;
    px(1'b0);
    px(1'b0);
    px(1'b0);
    px(1'b0);

    // 4: SOF at (2,1) restarts without frame-end blanking
`ifdef BAYER_FRAME_COUNT_EN
    fc_saved = fc;
`endif
    chk("restart_model_x", m_x, 2);
    px(1'b1);
    chk("restart_ready", {31'd0, rdy}, 32'd1);
`ifdef BAYER_FRAME_COUNT_EN
    chk("fc_restart_same", {12'd0, fc}, {12'd0, fc_saved});
`endif
    for (int i = 0; i < 7; i++) px(1'b0);
`ifdef BAYER_FRAME_COUNT_EN
    chk("fc_frame2", {12'd0, fc}, 32'd2);
`endif

    // 5: phase-3 instance picks blue at (0,0)
    px_rgb(1'b1, 12'hABC, 12'h123, 12'h456);
    chk("p3_data", {20'd0, p3_data}, 32'h456);
    chk("p3_valid", {31'd0, p3_valid}, 32'd1);
    chk("p3_xy", {8'd0, p3_x, p3_y}, 32'd0);

    // 6: asynchronous reset mid-frame at (1,1)
    for (int i = 0; i < 5; i++) px(1'b0);
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, b_valid}, 32'd0);
    chk("arst_xy", {8'd0, b_x, b_y}, 32'd0);
    chk("arst_ready", {31'd0, rdy}, 32'd0);
`ifdef BAYER_FRAME_COUNT_EN
    chk("arst_fc", {12'd0, fc}, 32'd0);
`endif
    @(negedge clk); #1;
    reset = 1'b0;
    chk("arst_queue", q.size(), 32'd0);
    q.delete();
    for (int f = 0; f < 2; f++) begin
      px(1'b1);
      for (int i = 0; i < 7; i++) px(1'b0);
    end
    repeat (10) @(negedge clk);
`ifdef BAYER_FRAME_COUNT_EN
    chk("fc_after_reset", {12'd0, fc}, 32'd2);
`endif
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
